output_streamer: RTL and testbench

Parametrised nibble serializer that captures N_WORDS words of W bits on a start request and streams them, most significant nibble first and word 0 first, as framed bytes on an 8-bit output port. It is the next-generation front end of the watchdog readout path, replacing the fixed two-word, 32-bit loader. It adds word/width generics, an abort input, a done pulse and an optional checksum trailer.

---
 rtl/output_streamer_pkg.sv | 36 +++
 rtl/output_streamer_stream_shift_reg.sv | 39 +++
 rtl/output_streamer.sv | 138 +++++++++++++
 tb/tb_output_streamer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_streamer_pkg.sv
// -----------------------------------------------------------------------------
// output_streamer_pkg
// Shared types and helpers for the output_streamer nibble serializer.
//   state_t     : FSM encoding (TRAIL exists only when the checksum trailer
//                 is built in, i.e. when OUTPUT_STREAMER_CHECKSUM_EN is defined)
//   OUT_MODE_W  : width of the frame tag carried in out_byte[7:5]
//   OUT_NIB_W   : width of the data nibble carried in out_byte[3:0]
//   VALID_BIT   : position of the valid flag inside out_byte
//   make_frame  : packs {mode, valid=1, nibble} into one output byte
// -----------------------------------------------------------------------------
package output_streamer_pkg;

   localparam int OUT_MODE_W = 3;
   localparam int OUT_NIB_W  = 4;
   localparam int VALID_BIT  = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEND  = 2'd1,
`ifdef OUTPUT_STREAMER_CHECKSUM_EN
      ST_TRAIL = 2'd2,
`endif
      ST_LAST  = 2'd3
   } state_t;

   function automatic logic [7:0] make_frame(input logic [OUT_MODE_W-1:0] mode,
                                             input logic [OUT_NIB_W-1:0]  nibble);
      logic [7:0] b;
      b                 = '0;
      b[7:5]            = mode;
      b[VALID_BIT]      = 1'b1;
      b[OUT_NIB_W-1:0]  = nibble;
      return b;
   endfunction

endpackage

// File: rtl/output_streamer_stream_shift_reg.sv
// -----------------------------------------------------------------------------
// stream_shift_reg
// Parallel-load shift register that feeds the serializer one nibble at a time.
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset (clears the register)
//   load       in   capture load_data (wins over advance)
//   advance    in   shift left by one nibble, zero filled
//   load_data  in   WIDTH-bit parallel image, first nibble in the top bits
//   top_nibble out  most significant nibble of the register
// -----------------------------------------------------------------------------
module stream_shift_reg
   import output_streamer_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic                 advance,
   input  logic [WIDTH-1:0]     load_data,
   output logic [OUT_NIB_W-1:0] top_nibble
);

   logic [WIDTH-1:0] sr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sr <= '0;
      end else if (load) begin
         sr <= load_data;
      end else if (advance) begin
         // Shift operator rather than a slice so WIDTH=4 stays legal.
         sr <= sr << OUT_NIB_W;
      end
   end

   assign top_nibble = sr[WIDTH-1 -: OUT_NIB_W];

endmodule

// File: rtl/output_streamer.sv
// -----------------------------------------------------------------------------
// output_streamer
// Captures N_WORDS words of W bits on a start request and streams them as
// framed bytes, word 0 first, most significant nibble first.
// Optional checksum trailer enabled by defining OUTPUT_STREAMER_CHECKSUM_EN:
// the frame then ends with {mode, 1, XOR of all nibbles}.
//
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   synchronous active-low reset
//   ena       in   clock enable for start acceptance and stream advance
//   start     in   frame request, honoured only in IDLE with ena=1
//   abort     in   cancel current frame at the next edge (ignores ena)
//   mode      in   3-bit frame tag, captured at start
//   words     in   N_WORDS*W bits, word i at [i*W +: W]
//   busy      out  high while a frame is in progress
//   done      out  one-cycle pulse after a normally completed frame
//   out_byte  out  {mode, valid, nibble} while streaming, 0x00 otherwise
//
// Handshake: there is no back-pressure. A request is taken when start=1,
// ena=1, abort=0 and busy=0 at a rising edge; requests while busy are dropped.
// -----------------------------------------------------------------------------
module output_streamer
   import output_streamer_pkg::*;
#(
   parameter int W       = 32,
   parameter int N_WORDS = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ena,
   input  logic                   start,
   input  logic                   abort,
   input  logic [OUT_MODE_W-1:0]  mode,
   input  logic [N_WORDS*W-1:0]   words,
   output logic                   busy,
   output logic                   done,
   output logic [7:0]             out_byte
);

   localparam int WIDTH = N_WORDS * W;
   localparam int NN    = WIDTH / OUT_NIB_W;
   localparam int CNT_W = $clog2(NN + 1);

   state_t                 state;
   logic [OUT_MODE_W-1:0]  cur_mode;
   logic [CNT_W-1:0]       cnt;
   logic [WIDTH-1:0]       load_data;
   logic [OUT_NIB_W-1:0]   top_nibble;
   logic                   load;
   logic                   advance;
`ifdef OUTPUT_STREAMER_CHECKSUM_EN
   logic [OUT_NIB_W-1:0]   csum;
`endif

   // Word 0 must leave first, so it is placed in the top bits of the image.
   always_comb begin
      load_data = '0;
      for (int i = 0; i < N_WORDS; i++) begin
         load_data[(N_WORDS-1-i)*W +: W] = words[i*W +: W];
      end
   end

   assign load    = ena && !abort && start && (state == ST_IDLE);
   assign advance = ena && !abort && (state == ST_SEND);

   stream_shift_reg #(.WIDTH(WIDTH)) u_shift (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .advance    (advance),
      .load_data  (load_data),
      .top_nibble (top_nibble)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cur_mode <= '0;
         cnt      <= '0;
         done     <= 1'b0;
         out_byte <= 8'h00;
`ifdef OUTPUT_STREAMER_CHECKSUM_EN
         csum     <= '0;
`endif
      end else if (abort) begin
         state    <= ST_IDLE;
         done     <= 1'b0;
         out_byte <= 8'h00;
      end else if (!ena) begin
         // Everything holds; only the done pulse is suppressed.
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               out_byte <= 8'h00;
               if (start) begin
                  cur_mode <= mode;
                  cnt      <= CNT_W'(NN);
`ifdef OUTPUT_STREAMER_CHECKSUM_EN
                  csum     <= '0;
`endif
                  state    <= ST_SEND;
               end
            end
            ST_SEND: begin
               out_byte <= make_frame(cur_mode, top_nibble);
               cnt      <= cnt - CNT_W'(1);
`ifdef OUTPUT_STREAMER_CHECKSUM_EN
               csum     <= csum ^ top_nibble;
               if (cnt == CNT_W'(1)) state <= ST_TRAIL;
`else
               if (cnt == CNT_W'(1)) state <= ST_LAST;
`endif
            end
`ifdef OUTPUT_STREAMER_CHECKSUM_EN
            ST_TRAIL: begin
               out_byte <= make_frame(cur_mode, csum);
               state    <= ST_LAST;
            end
`endif
            ST_LAST: begin
               out_byte <= 8'h00;
               done     <= 1'b1;
               state    <= ST_IDLE;
            end
            default: begin
               out_byte <= 8'h00;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_output_streamer.sv
// -----------------------------------------------------------------------------
// tb_output_streamer
// Two instances share all control inputs: u0 (W=32, N_WORDS=2) and
// u1 (W=8, N_WORDS=1). A frame-list model predicts every output each cycle:
// on acceptance it builds the complete byte list of the frame (nibbles,
// optional trailer, closing 0x00 with done) and then pops one entry per
// enabled edge.
// -----------------------------------------------------------------------------
module tb_output_streamer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ena;
   logic        start;
   logic        abort;
   logic [2:0]  mode;
   logic [63:0] words0;
   logic [7:0]  words1;
   logic        busy0, done0, busy1, done1;
   logic [7:0]  out0, out1;

   int checks   = 0;
   int failures = 0;
   logic cmp_en = 1'b0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   output_streamer #(.W(32), .N_WORDS(2)) u0 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .abort(abort),
      .mode(mode), .words(words0), .busy(busy0), .done(done0), .out_byte(out0)
   );

   output_streamer #(.W(8), .N_WORDS(1)) u1 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .abort(abort),
      .mode(mode), .words(words1), .busy(busy1), .done(done1), .out_byte(out1)
   );

   // ---------------- model ----------------
   logic [8:0] fr  [2][20];   // [8] = closing entry (done), [7:0] = byte
   int         pos [2];
   logic       act [2] = '{1'b0, 1'b0};
   logic [7:0] eo  [2] = '{8'h00, 8'h00};
   logic       ed  [2] = '{1'b0, 1'b0};

   function automatic void build_frame(input int u);
      int npw;
      int nn;
      int n;
      logic [63:0] wv;
      logic [3:0]  nib;
      logic [3:0]  cs;
      npw = (u == 0) ? 8 : 2;
      nn  = (u == 0) ? 16 : 2;
      wv  = (u == 0) ? words0 : {56'h0, words1};
      cs  = 4'h0;
      n   = 0;
      for (int j = 0; j < nn; j++) begin
         nib = 4'((wv >> ((j / npw) * npw * 4 + (npw - 1 - (j % npw)) * 4)) & 64'hF);
         cs  = cs ^ nib;
         fr[u][n] = {1'b0, mode, 1'b1, nib};
         n++;
      end
`ifdef OUTPUT_STREAMER_CHECKSUM_EN
      fr[u][n] = {1'b0, mode, 1'b1, cs};
      n++;
`endif
      fr[u][n] = 9'h100;
   endfunction

   always @(posedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (!rst_n) begin
            act[u] = 1'b0; eo[u] = 8'h00; ed[u] = 1'b0;
         end else if (abort) begin
            act[u] = 1'b0; eo[u] = 8'h00; ed[u] = 1'b0;
         end else if (!ena) begin
            ed[u] = 1'b0;
         end else if (!act[u]) begin
            eo[u] = 8'h00; ed[u] = 1'b0;
            if (start) begin
               build_frame(u);
               act[u] = 1'b1;
               pos[u] = 0;
            end
         end else begin
            eo[u] = fr[u][pos[u]][7:0];
            ed[u] = fr[u][pos[u]][8];
            if (fr[u][pos[u]][8]) act[u] = 1'b0;
            pos[u]++;
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] req);
      checks++;
      if (actual !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, actual, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("u0 out_byte", 32'(out0),  32'(eo[0]));
         chk("u0 done",     32'(done0), 32'(ed[0]));
         chk("u0 busy",     32'(busy0), 32'(act[0]));
         chk("u1 out_byte", 32'(out1),  32'(eo[1]));
         chk("u1 done",     32'(done1), 32'(ed[1]));
         chk("u1 busy",     32'(busy1), 32'(act[1]));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic pulse_start(input logic [2:0] m);
      @(negedge clk);
      mode  = m;
      start = 1'b1;
      ena   = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy0 || busy1) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("wait_idle in budget", 32'(n < 100), 32'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int dcnt;
      int n;
      rst_n = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0; mode = 3'b000;
      words0 = 64'h9ABCDEF0_12345678;
      words1 = 8'hA5;
      @(negedge clk);
      cmp_en = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset out_byte", 32'(out0), 32'h00);
      chk("reset busy",     32'(busy0), 32'd0);
      chk("reset done",     32'(done0), 32'd0);
      rst_n = 1'b1;

      // Basic frame, mode 101, W=32 x2
      pulse_start(3'b101);
      chk("start busy", 32'(busy0), 32'd1);
      chk("start out",  32'(out0),  32'h00);
      for (int j = 1; j <= 16; j++) begin
         @(negedge clk);
         chk("frame nibble", 32'(out0), 32'(8'hB0 | 8'(j % 16)));
      end
`ifdef OUTPUT_STREAMER_CHECKSUM_EN
      @(negedge clk);
      chk("trailer", 32'(out0), 32'hB0);
`endif
      @(negedge clk);
      chk("end out",  32'(out0),  32'h00);
      chk("end done", 32'(done0), 32'd1);
      chk("end busy", 32'(busy0), 32'd0);
      @(negedge clk);
      chk("done one cycle", 32'(done0), 32'd0);

      // Small instance, mode 111, word 0xA5
      wait_idle();
      pulse_start(3'b111);
      @(negedge clk); chk("small n1", 32'(out1), 32'hFA);
      @(negedge clk); chk("small n2", 32'(out1), 32'hF5);
`ifdef OUTPUT_STREAMER_CHECKSUM_EN
      @(negedge clk); chk("small trailer", 32'(out1), 32'hFF);
`endif
      @(negedge clk);
      chk("small end out",  32'(out1),  32'h00);
      chk("small end done", 32'(done1), 32'd1);

      // ena toggling 1,0: values held two cycles, one done pulse
      wait_idle();
      pulse_start(3'b101);
      dcnt = 0;
      for (int i = 0; i < 50; i++) begin
         ena = ~ena;
         @(negedge clk);
         if (done0) dcnt++;
      end
      ena = 1'b1;
      chk("toggle done count", 32'(dcnt), 32'd1);

      // Abort after three nibbles
      wait_idle();
      pulse_start(3'b101);
      for (int j = 1; j <= 3; j++) begin
         @(negedge clk);
         chk("pre-abort nibble", 32'(out0), 32'(8'hB0 | 8'(j)));
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort out",  32'(out0), 32'h00);
      chk("abort busy", 32'(busy0), 32'd0);
      pulse_start(3'b101);
      @(negedge clk);
      chk("restart nibble", 32'(out0), 32'hB1);

      // Start held through the frame and LAST; new mode taken on done cycle
      wait_idle();
      @(negedge clk);
      mode = 3'b101; start = 1'b1; ena = 1'b1;
      @(negedge clk);
      mode = 3'b010;
      n = 0;
      while (!done0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("done seen in budget", 32'(n < 40), 32'd1);
      @(negedge clk);
      start = 1'b0;
      chk("restart busy", 32'(busy0), 32'd1);
      chk("restart out",  32'(out0),  32'h00);
      @(negedge clk);
      chk("restart tag", 32'(out0[7:4]), 32'h5);

      // Reset for one edge mid-frame with ena low
      wait_idle();
      pulse_start(3'b110);
      repeat (4) @(negedge clk);
      ena = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midreset out",  32'(out0),  32'h00);
      chk("midreset busy", 32'(busy0), 32'd0);
      ena = 1'b1;
      repeat (5) @(negedge clk);
      chk("post-reset idle out", 32'(out0), 32'h00);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         rst_n  = ($urandom_range(0, 99) != 0);
         ena    = ($urandom_range(0, 3) != 0);
         start  = ($urandom_range(0, 7) == 0);
         abort  = ($urandom_range(0, 39) == 0);
         mode   = 3'($urandom_range(0, 7));
         words0 = {$urandom, $urandom};
         words1 = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
      rst_n = 1'b1; ena = 1'b1; start = 1'b0; abort = 1'b0;
      wait_idle();
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
